// File: rtl/branch_perf_monitor.sv
// Branch/instruction performance counters for the always-taken core, with a
// registered one-cycle read port for the LCD/debug path.
module branch_perf_monitor #(
    parameter int unsigned CNT_W      = 32,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_start,
    input  logic        i_clr,
    input  logic        i_insn_vld,
    input  logic        i_is_br,
    input  logic        i_is_jmp,
    input  logic        i_flush,
    input  logic        i_halt,
    input  logic        i_rd_en,
    input  logic [2:0]  i_rd_addr,
    output logic [31:0] o_rd_data,
    output logic        o_rd_vld,
    output logic        o_running,
    output logic        o_done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int unsigned      N_CNT = 5;
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_t                        state_q, state_d;
    logic [N_CNT-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_CNT-1:0]              inc;
    logic                          ovf_q, ovf_d;
    logic [31:0]                   rd_data_q, rd_data_d;
    logic                          rd_vld_q;
    logic                          evt_br;
    logic [31:0]                   rd_mux;

    always_comb begin
        state_d = state_q;
        if (i_clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (AUTO_START || i_start) state_d = RUN;
                RUN:     if (i_halt) state_d = DONE;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Slot order matches the read address map: cyc, ins, br, miss, corr.
    always_comb begin
        evt_br = i_is_br | i_is_jmp;
        inc    = {evt_br & ~i_flush, evt_br & i_flush, evt_br, i_insn_vld, 1'b1};
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        if (i_clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (state_q == RUN) begin
            for (int unsigned i = 0; i < N_CNT; i++) begin
                if (inc[i]) begin
                    if (&cnt_q[i]) ovf_d = 1'b1;
                    else           cnt_d[i] = cnt_q[i] + ONE;
                end
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (i_rd_addr)
            3'd0:    rd_mux[CNT_W-1:0] = cnt_q[0];
            3'd1:    rd_mux[CNT_W-1:0] = cnt_q[1];
            3'd2:    rd_mux[CNT_W-1:0] = cnt_q[2];
            3'd3:    rd_mux[CNT_W-1:0] = cnt_q[3];
            3'd4:    rd_mux[CNT_W-1:0] = cnt_q[4];
            3'd5:    rd_mux = {29'b0, ovf_q, state_q == DONE, state_q == RUN};
            default: rd_mux = '0;
        endcase
        rd_data_d = i_rd_en ? rd_mux : rd_data_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            rd_data_q <= '0;
            rd_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            rd_data_q <= rd_data_d;
            rd_vld_q  <= i_rd_en;
        end
    end

    assign o_rd_data = rd_data_q;
    assign o_rd_vld  = rd_vld_q;
    assign o_running = (state_q == RUN);
    assign o_done    = (state_q == DONE);

endmodule

// File: tb/tb_branch_perf_monitor.sv
// Directed bench: a 32-bit auto-start monitor (A) and a 4-bit manual-start
// monitor (B) share stimulus; each is exercised while the other is in reset.
module tb_branch_perf_monitor;

    logic        clk = 1'b0;
    logic        rstn_a = 1'b0, rstn_b = 1'b0;
    logic        start = 1'b0, clr = 1'b0, insn_vld = 1'b0, is_br = 1'b0;
    logic        is_jmp = 1'b0, flush = 1'b0, halt = 1'b0, rd_en = 1'b0;
    logic [2:0]  rd_addr = '0;
    logic [31:0] data_a, data_b;
    logic        vld_a, vld_b, run_a, run_b, done_a, done_b;
    int          n_cmp = 0, n_fail = 0;

    always #5 clk = ~clk;

    branch_perf_monitor #(.CNT_W(32), .AUTO_START(1'b1)) u_a (
        .i_clk(clk), .i_rstn(rstn_a), .i_start(start), .i_clr(clr),
        .i_insn_vld(insn_vld), .i_is_br(is_br), .i_is_jmp(is_jmp),
        .i_flush(flush), .i_halt(halt), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
        .o_rd_data(data_a), .o_rd_vld(vld_a), .o_running(run_a), .o_done(done_a)
    );

    branch_perf_monitor #(.CNT_W(4), .AUTO_START(1'b0)) u_b (
        .i_clk(clk), .i_rstn(rstn_b), .i_start(start), .i_clr(clr),
        .i_insn_vld(insn_vld), .i_is_br(is_br), .i_is_jmp(is_jmp),
        .i_flush(flush), .i_halt(halt), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
        .o_rd_data(data_b), .o_rd_vld(vld_b), .o_running(run_b), .o_done(done_b)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-edge read; also confirms the valid pulse.
    task automatic rd(input bit b, input logic [2:0] a, input logic [31:0] exp, input string tag);
        rd_en   = 1'b1;
        rd_addr = a;
        tick(1);
        rd_en   = 1'b0;
        check({tag, "_vld"}, {31'b0, b ? vld_b : vld_a}, 32'd1);
        check(tag, b ? data_b : data_a, exp);
    endtask

    task automatic clr_a;
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("clr_idle", {31'b0, run_a}, 32'd0);
        tick(1);
    endtask

    initial begin
        // Reset state of A
        tick(2);
        check("rst_data", data_a, 32'd0);
        check("rst_vld", {31'b0, vld_a}, 32'd0);
        check("rst_run", {31'b0, run_a}, 32'd0);
        check("rst_done", {31'b0, done_a}, 32'd0);

        // Auto-start, 10 idle RUN cycles; each read edge is itself a RUN cycle
        rstn_a = 1'b1;
        tick(1);
        check("auto_run", {31'b0, run_a}, 32'd1);
        tick(10);
        rd(0, 3'd0, 32'd10, "t1_cyc");
        tick(1);
        check("t1_vld_drop", {31'b0, vld_a}, 32'd0);
        check("t1_hold", data_a, 32'd10);
        rd(0, 3'd1, 32'd0, "t1_ins");
        rd(0, 3'd2, 32'd0, "t1_br");
        rd(0, 3'd3, 32'd0, "t1_miss");
        rd(0, 3'd4, 32'd0, "t1_corr");
        rd(0, 3'd5, 32'd1, "t1_stat");
        rd(0, 3'd6, 32'd0, "t1_a6");

        // 6 branches (2 flushed) plus 3 stray flushes
        clr_a();
        for (int k = 0; k < 6; k++) begin
            is_br = 1'b1;
            flush = (k < 2);
            tick(1);
        end
        is_br = 1'b0;
        flush = 1'b1;
        tick(3);
        flush = 1'b0;
        rd(0, 3'd2, 32'd6, "t2_br");
        rd(0, 3'd3, 32'd2, "t2_miss");
        rd(0, 3'd4, 32'd4, "t2_corr");

        // Branch and jump together count once
        clr_a();
        is_br = 1'b1;
        is_jmp = 1'b1;
        tick(1);
        is_br = 1'b0;
        is_jmp = 1'b0;
        rd(0, 3'd2, 32'd1, "t3_br");
        rd(0, 3'd4, 32'd1, "t3_corr");
        rd(0, 3'd3, 32'd0, "t3_miss");

        // Halt after 20 RUN cycles with an instruction in the halt cycle
        clr_a();
        tick(20);
        halt = 1'b1;
        insn_vld = 1'b1;
        tick(1);
        halt = 1'b0;
        insn_vld = 1'b0;
        check("t4_done", {31'b0, done_a}, 32'd1);
        check("t4_run", {31'b0, run_a}, 32'd0);
        tick(5);
        rd(0, 3'd0, 32'd21, "t4_cyc");
        rd(0, 3'd1, 32'd1, "t4_ins");
        rd(0, 3'd5, 32'd2, "t4_stat");
        tick(3);
        rd(0, 3'd0, 32'd21, "t4_cyc_frozen");

        // Read coinciding with an increment returns the old value
        clr_a();
        insn_vld = 1'b1;
        tick(7);
        rd(0, 3'd1, 32'd7, "t6_pre_inc");
        insn_vld = 1'b0;
        rd(0, 3'd1, 32'd8, "t6_post_inc");
        tick(1);
        check("t6_vld_drop", {31'b0, vld_a}, 32'd0);
        check("t6_hold", data_a, 32'd8);

        // Mid-run reset
        rstn_a = 1'b0;
        tick(1);
        check("t6_rst_data", data_a, 32'd0);
        check("t6_rst_vld", {31'b0, vld_a}, 32'd0);
        check("t6_rst_run", {31'b0, run_a}, 32'd0);
        rstn_a = 1'b1;
        rd(0, 3'd0, 32'd0, "t6_rst_cyc");
        rd(0, 3'd1, 32'd0, "t6_rst_ins");
        rstn_a = 1'b0;

        // B: manual start, 4-bit saturation
        rstn_b = 1'b1;
        tick(3);
        check("b_wait_start", {31'b0, run_b}, 32'd0);
        rd(1, 3'd0, 32'd0, "b_idle_cyc");
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("b_run", {31'b0, run_b}, 32'd1);
        tick(18);
        rd(1, 3'd0, 32'd15, "b_sat_cyc");
        rd(1, 3'd5, 32'd5, "b_stat_ovf");
        clr = 1'b1;
        rd(1, 3'd0, 32'd15, "b_rd_with_clr");
        clr = 1'b0;
        check("b_clr_idle", {31'b0, run_b}, 32'd0);
        rd(1, 3'd0, 32'd0, "b_clr_cyc");
        rd(1, 3'd5, 32'd0, "b_clr_stat");
        rd(1, 3'd4, 32'd0, "b_clr_corr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_perf_monitor.md
Name: branch_perf_monitor

Overview:
- Hardware performance monitor attached downstream of the always-taken pipelined core.
- Consumes the core's retire and branch-resolution strobes: instruction valid, EX/MEM branch, EX/MEM unconditional jump, and the IF flush used as the mispredict indication.
- Accumulates cycle, instruction, branch, miss and correct counts in hardware, so on-board runs give the same statistics the simulation bench reports.
- Counters are read through a small registered read port for the LCD/debug path.

Parameters:
CNT_W, 32, width of each event counter (1..32); read data is zero-extended to 32 bits
AUTO_START, 1, 1 = leave IDLE on the first cycle after reset; 0 = wait for i_start

Ports:
i_clk  in  1  clock
i_rstn  in  1  synchronous active-low reset
i_start  in  1  begin counting (used only when AUTO_START=0)
i_clr  in  1  synchronous clear of all counters and state, back to IDLE
i_insn_vld  in  1  core o_insn_vld: one instruction retired this cycle
i_is_br  in  1  EX/MEM conditional branch resolved this cycle
i_is_jmp  in  1  EX/MEM unconditional jump resolved this cycle
i_flush  in  1  core IF_flush (mispredict / redirect)
i_halt  in  1  end-of-program detected (fetched word 0x11111111)
i_rd_en  in  1  read request
i_rd_addr  in  3  counter select
o_rd_data  out  32  read data
o_rd_vld  out  1  read data valid
o_running  out  1  state == RUN
o_done  out  1  state == DONE

Behaviour:
- Reset: when i_rstn=0 at a rising edge, the block enters IDLE and clears all counters and the overflow flag. It also drives o_rd_data=0, o_rd_vld=0, o_running=0 and o_done=0. Reset mid-run discards all counts.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when AUTO_START=1 (next cycle), or when i_start=1 with AUTO_START=0.
  - RUN -> DONE when i_halt=1.
  - DONE holds until i_clr or reset.
  - Any state -> IDLE on i_clr=1. Counters and the overflow flag are zeroed in the same edge.
- Priority: reset > i_clr > halt/count.
- Counting happens only in RUN, one update per edge:
  - cyc += 1 every RUN cycle.
  - ins += 1 when i_insn_vld.
  - br += 1 when (i_is_br | i_is_jmp). Both high counts as one branch.
  - miss += 1 when (i_is_br | i_is_jmp) & i_flush.
  - corr += 1 when (i_is_br | i_is_jmp) & ~i_flush.
  - i_flush without a branch/jump is ignored.
- Halt cycle: events present in the same cycle as i_halt, including the cycle count, are counted. The counters are then frozen in DONE.
- Invariant at all times: br == miss + corr, unless a counter has saturated.
- Saturation:
  - Each counter stops at 2^CNT_W-1 and never wraps.
  - The first attempt to increment a saturated counter sets a sticky ovf flag, cleared only by i_clr or reset.
- Read port:
  - Latency is 1 cycle. i_rd_en sampled at edge N gives o_rd_vld=1 and o_rd_data after edge N, for one cycle.
  - o_rd_vld=0 whenever i_rd_en was 0 at the previous edge.
  - o_rd_data holds its last value when not reading.
  - Reads are allowed in any state and do not disturb counting.
  - A read in the same cycle as an increment returns the pre-increment value.
- Address map:
  - 0 = cyc, 1 = ins, 2 = br, 3 = miss, 4 = corr.
  - 5 = status {29'b0, ovf, done, running}.
  - 6 and 7 = 0.
- Counters narrower than 32 bits are zero-extended on the read port.
- A read in the same cycle as i_clr returns the pre-clear value.

Test Plan:
- Reset then AUTO_START=1, 10 RUN cycles, no events -> read addr0 = 10; addr1..4 = 0; status = 0x1.
- In RUN, 6 branch strobes with i_flush on 2 of them, plus 3 flushes without a branch -> br=6, miss=2, corr=4.
- i_is_br and i_is_jmp both high for one cycle with i_flush=0 -> br=1, corr=1.
- i_halt together with i_insn_vld after 20 RUN cycles, then 5 more edges -> cyc=21, ins includes the halt cycle, status = 0x2, counters unchanged on later reads.
- CNT_W=4, 18 RUN cycles -> cyc=15, status ovf bit=1. Then i_clr -> all reads 0, state IDLE.
- i_rd_en addr1 on the same edge as an i_insn_vld increment (ins 7->8) -> o_rd_vld pulses one cycle with data 7. A second read gives 8. Assert i_rstn=0 mid-RUN -> all outputs and counters 0.
